key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/key_pkg.sv | 16 +
 rtl/key_debounce.sv | 70 +++++++
 rtl/key_scan.sv | 89 ++++++++
 tb/tb_key_scan.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and scan-state encoding for the keypad scanner
package key_pkg;

    localparam logic [3:0] NO_KEY   = 4'd0;
    localparam int         NUM_ROWS = 4;
    localparam int         NUM_COLS = 4;
    localparam logic [3:0] MAX_CODE = 4'd13;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } scan_state_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - frame-rate debounce of the scanned candidate and key commit
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic [3:0] frame_cand,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_release
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

    logic [3:0] prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] key_q, key_d;
    logic       valid_q, valid_d;
    logic       rel_q, rel_d;

    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;

        if (frame_end) begin
            if (frame_cand == prev_q) begin
                if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                prev_d = frame_cand;
                cnt_d  = 4'd1;
            end
        end

        // Commit one cycle after the count saturates; fires once since key then matches prev.
        if (cnt_q == CNT_MAX && prev_q != key_q) begin
            key_d   = prev_q;
            valid_d = (prev_q != NO_KEY);
            rel_d   = (prev_q == NO_KEY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= NO_KEY;
            cnt_q   <= 4'd0;
            key_q   <= NO_KEY;
            valid_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            rel_q   <= rel_d;
        end
    end

    assign key         = key_q;
    assign key_valid   = valid_q;
    assign key_release = rel_q;

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - 4x4 keypad row scanner with column synchronizer and debounced key output
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_release
);

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    scan_state_e state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  cand_q, cand_d;

    logic        last;
    logic [3:0]  pos;
    logic [3:0]  row_code;
    logic [3:0]  frame_code;
    logic        frame_end;

    // Columns scanned high-to-low so the lowest pressed position in the row wins.
    always_comb begin
        row_code = NO_KEY;
        pos      = 4'd0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            pos = {state_q, 2'(c)};
            if (!sync2_q[c] && pos < MAX_CODE) begin
                row_code = pos + 4'd1;
            end
        end
    end

    always_comb begin
        sync1_d = col_in;
        sync2_d = sync1_q;
        last    = (div_q == DIV_LAST);
        div_d   = last ? 8'd0 : div_q + 8'd1;
        state_d = last ? scan_state_e'(state_q + 2'd1) : state_q;

        // Earlier rows hold lower positions, so a code already found this frame takes priority.
        frame_code = (cand_q != NO_KEY) ? cand_q : row_code;
        frame_end  = last && (state_q == ROW3);
        cand_d     = cand_q;
        if (last) begin
            cand_d = frame_end ? NO_KEY : frame_code;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
            state_q <= ROW0;
            div_q   <= 8'd0;
            cand_q  <= NO_KEY;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            div_q   <= div_d;
            cand_q  <= cand_d;
        end
    end

    assign row_out = ~(4'b0001 << state_q);

    key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk        (sysclk),
        .rst_n      (rst_n),
        .frame_end  (frame_end),
        .frame_cand (frame_code),
        .key        (key),
        .key_valid  (key_valid),
        .key_release(key_release)
    );

endmodule

// File: tb/tb_key_scan.sv
// tb/tb_key_scan.sv - self-checking bench for key_scan against a frame-level keypad model
module tb_key_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key;
    logic       key_valid;
    logic       key_release;

    logic [15:0] mask;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] m_prev, m_cnt, m_key, pend_key;
    logic       pend;
    int         cyc, cycle_errs, bad_cyc, n_valid, n_rel, chg_cyc;
    logic [3:0] chg_ref, bad_key;

    key_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEB)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .col_in     (col_in),
        .row_out    (row_out),
        .key        (key),
        .key_valid  (key_valid),
        .key_release(key_release)
    );

    always #5 sysclk = ~sysclk;

    // Passive keypad: a pressed switch shorts the driven (low) row onto its column.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (row_out[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (mask[r * 4 + c]) col_in[c] = 1'b0;
                end
            end
        end
    end

    function automatic logic [3:0] frame_code(input logic [15:0] m);
        for (int p = 0; p <= 12; p++) begin
            if (m[p]) return 4'(p + 1);
        end
        return 4'd0;
    endfunction

    task automatic reset_model();
        m_prev = 0; m_cnt = 0; m_key = 0; pend = 0; pend_key = 0; cyc = 0;
    endtask

    task automatic clear_obs();
        cycle_errs = 0; bad_cyc = -1; bad_key = 0; n_valid = 0; n_rel = 0;
        chg_cyc = -1; chg_ref = m_key;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
        reset_model();
    endtask

    // Holds one keypad pattern for a whole frame, starting at the negedge of the frame's first cycle.
    task automatic run_frame(input logic [15:0] m);
        logic [3:0] cand, exp_row;
        logic       exp_valid, exp_rel;
        mask = m;
        for (int i = 0; i < FRAME; i++) begin
            exp_valid = 1'b0;
            exp_rel   = 1'b0;
            if (i == 1 && pend) begin
                exp_valid = (pend_key != 0);
                exp_rel   = (pend_key == 0);
                m_key     = pend_key;
                pend      = 1'b0;
            end
            exp_row = 4'b1111;
            exp_row[i / SCAN_DIV] = 1'b0;
            if (row_out !== exp_row || key !== m_key || key_valid !== exp_valid || key_release !== exp_rel) begin
                if (cycle_errs == 0) begin
                    bad_cyc = cyc;
                    bad_key = key;
                end
                cycle_errs++;
            end
            if (key_valid === 1'b1) n_valid++;
            if (key_release === 1'b1) n_rel++;
            if (chg_cyc < 0 && key !== chg_ref) chg_cyc = cyc;
            @(posedge sysclk);
            @(negedge sysclk);
            cyc++;
        end
        cand = frame_code(m);
        if (cand == m_prev) begin
            if (m_cnt < DEB) m_cnt++;
        end else begin
            m_prev = cand;
            m_cnt  = 1;
        end
        if (m_cnt == DEB && cand != m_key) begin
            pend     = 1'b1;
            pend_key = cand;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mask  = 16'h0000;
        repeat (3) @(negedge sysclk);
        compared++;
        if (row_out !== 4'b1110) begin mismatched++; $display("FAIL reset_row_out: got %b expected 1110", row_out); end
        compared++;
        if (key !== 4'd0) begin mismatched++; $display("FAIL reset_key: got %0d expected 0", key); end
        compared++;
        if (key_valid !== 1'b0) begin mismatched++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        compared++;
        if (key_release !== 1'b0) begin mismatched++; $display("FAIL reset_key_release: got %b expected 0", key_release); end
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_bounce();
        clear_obs();
        for (int f = 0; f < 4; f++) run_frame((f % 2 == 0) ? 16'h0040 : 16'h0000);
        run_frame(16'h0000);
        compared++;
        if (cycle_errs !== 0) begin mismatched++; $display("FAIL bounce_timeline: %0d bad cycles, first at %0d key %0d, expected 0", cycle_errs, bad_cyc, bad_key); end
        compared++;
        if (key !== 4'd0) begin mismatched++; $display("FAIL bounce_key: got %0d expected 0", key); end
        compared++;
        if (n_valid !== 0 || n_rel !== 0) begin mismatched++; $display("FAIL bounce_pulses: got valid %0d release %0d expected 0 0", n_valid, n_rel); end
    endtask

    task automatic test_hold_press();
        do_reset();
        clear_obs();
        repeat (5) run_frame(16'h0040);
        compared++;
        if (cycle_errs !== 0) begin mismatched++; $display("FAIL hold_timeline: %0d bad cycles, first at %0d key %0d, expected 0", cycle_errs, bad_cyc, bad_key); end
        compared++;
        if (key !== 4'd7) begin mismatched++; $display("FAIL hold_key: got %0d expected 7", key); end
        compared++;
        if (chg_cyc !== 3 * FRAME + 1) begin mismatched++; $display("FAIL hold_latency: got cycle %0d expected %0d", chg_cyc, 3 * FRAME + 1); end
        compared++;
        if (n_valid !== 1 || n_rel !== 0) begin mismatched++; $display("FAIL hold_pulses: got valid %0d release %0d expected 1 0", n_valid, n_rel); end
    endtask

    task automatic test_release();
        cyc = 0;
        clear_obs();
        repeat (5) run_frame(16'h0000);
        compared++;
        if (key !== 4'd0) begin mismatched++; $display("FAIL release_key: got %0d expected 0", key); end
        compared++;
        if (chg_cyc !== 3 * FRAME + 1) begin mismatched++; $display("FAIL release_latency: got cycle %0d expected %0d", chg_cyc, 3 * FRAME + 1); end
        compared++;
        if (n_rel !== 1 || n_valid !== 0) begin mismatched++; $display("FAIL release_pulses: got valid %0d release %0d expected 0 1", n_valid, n_rel); end
        compared++;
        if (cycle_errs !== 0) begin mismatched++; $display("FAIL release_timeline: %0d bad cycles, first at %0d key %0d, expected 0", cycle_errs, bad_cyc, bad_key); end
    endtask

    task automatic test_multi_key();
        clear_obs();
        repeat (5) run_frame(16'h0102);
        compared++;
        if (key !== 4'd2) begin mismatched++; $display("FAIL multi_lowest_key: got %0d expected 2", key); end
        compared++;
        if (n_valid !== 1) begin mismatched++; $display("FAIL multi_lowest_valid: got %0d pulses expected 1", n_valid); end
        clear_obs();
        repeat (5) run_frame(16'h0100);
        compared++;
        if (key !== 4'd9) begin mismatched++; $display("FAIL multi_switch_key: got %0d expected 9", key); end
        compared++;
        if (n_valid !== 1 || n_rel !== 0) begin mismatched++; $display("FAIL multi_switch_pulses: got valid %0d release %0d expected 1 0", n_valid, n_rel); end
        compared++;
        if (cycle_errs !== 0) begin mismatched++; $display("FAIL multi_timeline: %0d bad cycles, first at %0d key %0d, expected 0", cycle_errs, bad_cyc, bad_key); end
    endtask

    task automatic test_ignored_keys();
        logic [15:0] m;
        repeat (5) run_frame(16'h0000);
        clear_obs();
        for (int f = 0; f < 6; f++) begin
            m = 16'h0000;
            m[4'($urandom_range(13, 15))] = 1'b1;
            run_frame(m);
        end
        compared++;
        if (key !== 4'd0) begin mismatched++; $display("FAIL ignored_key: got %0d expected 0", key); end
        compared++;
        if (n_valid !== 0 || n_rel !== 0) begin mismatched++; $display("FAIL ignored_pulses: got valid %0d release %0d expected 0 0", n_valid, n_rel); end
        compared++;
        if (cycle_errs !== 0) begin mismatched++; $display("FAIL ignored_timeline: %0d bad cycles, first at %0d key %0d, expected 0", cycle_errs, bad_cyc, bad_key); end
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        clear_obs();
        repeat (4) run_frame(16'h0040);
        compared++;
        if (key !== 4'd7) begin mismatched++; $display("FAIL midrst_pre_key: got %0d expected 7", key); end
        mask = 16'h0040;
        repeat ($urandom_range(0, FRAME - 1)) @(negedge sysclk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (key !== 4'd0 || key_valid !== 1'b0 || key_release !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_async_outputs: got key %0d valid %b release %b expected 0 0 0", key, key_valid, key_release);
        end
        compared++;
        if (row_out !== 4'b1110) begin mismatched++; $display("FAIL midrst_row_out: got %b expected 1110", row_out); end
        @(negedge sysclk);
        rst_n = 1'b1;
        reset_model();
        clear_obs();
        repeat (5) run_frame(16'h0040);
        compared++;
        if (key !== 4'd7 || chg_cyc !== 3 * FRAME + 1) begin mismatched++; $display("FAIL midrst_redetect: got key %0d at cycle %0d expected 7 at %0d", key, chg_cyc, 3 * FRAME + 1); end
        compared++;
        if (n_valid !== 1 || n_rel !== 0) begin mismatched++; $display("FAIL midrst_pulses: got valid %0d release %0d expected 1 0", n_valid, n_rel); end
        compared++;
        if (cycle_errs !== 0) begin mismatched++; $display("FAIL midrst_timeline: %0d bad cycles, first at %0d key %0d, expected 0", cycle_errs, bad_cyc, bad_key); end
    endtask

    task automatic test_random();
        logic [15:0] m;
        int          nk, hold;
        clear_obs();
        for (int s = 0; s < 30; s++) begin
            m  = 16'h0000;
            nk = $urandom_range(0, 3);
            for (int k = 0; k < nk; k++) m[4'($urandom_range(0, 15))] = 1'b1;
            hold = $urandom_range(1, 5);
            for (int f = 0; f < hold; f++) run_frame(m);
        end
        compared++;
        if (cycle_errs !== 0) begin mismatched++; $display("FAIL random_timeline: %0d bad cycles, first at %0d key %0d, expected 0", cycle_errs, bad_cyc, bad_key); end
        compared++;
        if (n_valid + n_rel === 0) begin mismatched++; $display("FAIL random_activity: got 0 key changes expected at least 1"); end
    endtask

    initial begin
        rst_n = 1'b0;
        mask  = 16'h0000;
        reset_model();
        clear_obs();
        @(negedge sysclk);
        test_reset();
        test_bounce();
        test_hold_press();
        test_release();
        test_multi_key();
        test_ignored_keys();
        test_reset_mid_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
